// File: rtl/vdp_pkg.sv
// Shared types for the VDP CPU port: port codes, queued VRAM operations and
// the VRAM access state machine encoding.
package vdp_pkg;

  localparam int unsigned VRAM_ADDR_W = 14;

  typedef enum logic [1:0] {
    VRAM_RD = 2'd0,
    VRAM_WR = 2'd1,
    REG_WR  = 2'd2,
    CRAM_WR = 2'd3
  } port_code_t;

  typedef enum logic {
    OP_WRITE    = 1'b0,
    OP_PREFETCH = 1'b1
  } op_kind_t;

  typedef struct packed {
    op_kind_t                 kind;
    logic [VRAM_ADDR_W-1:0]   addr;
    logic [7:0]               data;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RD_ADDR = 2'd2,
    ST_RD_CAP  = 2'd3
  } vram_state_t;

endpackage

// File: rtl/vdp_port_fifo.sv
// Synchronous FIFO of queued VRAM operations. Pushes while full and pops
// while empty are ignored; the caller decides what a dropped push means.
module vdp_port_fifo
  import vdp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  fifo_entry_t                    i_din,
  input  logic                           i_pop,
  output fifo_entry_t                    o_dout,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fifo_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          w_doPush;
  logic          w_doPop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_dout   = r_mem[r_rdPtr];
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_din;
  end

endmodule

// File: rtl/vdp_cpu_port.sv
// Z80-facing VDP port: decodes data/control accesses into queued VRAM
// writes/prefetches, CRAM writes and register writes; drives VRAM while granted.
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpuWr,
  input  logic                   cpuRd,
  input  logic                   cpuPortSel,
  input  logic [7:0]             cpuDin,
  output logic [7:0]             cpuDout,
  input  logic [7:0]             statusIn,
  output logic                   statusRead,
  input  logic                   vramGrant,
  output logic [VRAM_ADDR_W-1:0] vramAddr,
  output logic                   vramWe,
  output logic [7:0]             vramWrData,
  input  logic [7:0]             vramOut,
  output logic [4:0]             cramAddr,
  output logic [5:0]             cramData,
  output logic                   cramWe,
  output logic [3:0]             regAddr,
  output logic [7:0]             regData,
  output logic                   regWe,
  output logic                   fifoFull,
  output logic                   overflow,
  output logic                   prefetchBusy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);

  logic [VRAM_ADDR_W-1:0] r_addr;
  port_code_t             r_code;
  logic [7:0]             r_addrLow;
  logic                   r_latch;
  logic [7:0]             r_readBuf;
  logic [CW-1:0]          r_pfCount;
  vram_state_t            r_state;

  logic                   w_wr;
  logic                   w_rd;
  logic                   w_ctrlWr2;
  logic                   w_dataWr;
  logic                   w_dataRd;
  port_code_t             w_newCode;
  logic [VRAM_ADDR_W-1:0] w_ctrlAddr;
  logic                   w_enq;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [CW-1:0]          w_count;
  fifo_entry_t            w_enqEntry;
  fifo_entry_t            w_head;

  // A write wins over a simultaneous read.
  assign w_wr       = cpuWr;
  assign w_rd       = cpuRd & ~cpuWr;
  assign w_ctrlWr2  = w_wr & cpuPortSel & r_latch;
  assign w_dataWr   = w_wr & ~cpuPortSel;
  assign w_dataRd   = w_rd & ~cpuPortSel;
  assign w_newCode  = port_code_t'(cpuDin[7:6]);
  assign w_ctrlAddr = {cpuDin[5:0], r_addrLow};

  always_comb begin
    w_enq      = 1'b0;
    w_enqEntry = '{kind: OP_WRITE, addr: r_addr, data: cpuDin};
    if (w_ctrlWr2 && (w_newCode == VRAM_RD)) begin
      w_enq           = 1'b1;
      w_enqEntry.kind = OP_PREFETCH;
      w_enqEntry.addr = w_ctrlAddr;
    end else if (w_dataWr && (r_code != CRAM_WR)) begin
      w_enq = 1'b1;
    end else if (w_dataRd) begin
      w_enq           = 1'b1;
      w_enqEntry.kind = OP_PREFETCH;
    end
  end

  assign w_push       = w_enq & ~w_full;
  assign w_pop        = (r_state == ST_IDLE) & vramGrant & ~w_empty;
  assign fifoFull     = (w_count == CW'(FIFO_DEPTH));
  assign prefetchBusy = (r_pfCount != '0) || (r_state == ST_RD_ADDR) ||
                        (r_state == ST_RD_CAP);

  vdp_port_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_enqEntry),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_code     <= VRAM_RD;
      r_addrLow  <= '0;
      r_latch    <= 1'b0;
      r_readBuf  <= '0;
      cpuDout    <= '0;
      statusRead <= 1'b0;
      cramAddr   <= '0;
      cramData   <= '0;
      cramWe     <= 1'b0;
      regAddr    <= '0;
      regData    <= '0;
      regWe      <= 1'b0;
    end else begin
      statusRead <= 1'b0;
      cramWe     <= 1'b0;
      regWe      <= 1'b0;
      if (w_wr) begin
        if (cpuPortSel) begin
          if (!r_latch) begin
            r_addrLow <= cpuDin;
            r_latch   <= 1'b1;
          end else begin
            r_latch <= 1'b0;
            r_code  <= w_newCode;
            r_addr  <= (w_newCode == VRAM_RD) ? w_ctrlAddr + 1'b1 : w_ctrlAddr;
            if (w_newCode == REG_WR) begin
              regWe   <= 1'b1;
              regAddr <= cpuDin[3:0];
              regData <= r_addrLow;
            end
          end
        end else begin
          r_latch <= 1'b0;
          if (r_code == CRAM_WR) begin
            cramWe   <= 1'b1;
            cramAddr <= r_addr[4:0];
            cramData <= cpuDin[5:0];
          end
          r_readBuf <= cpuDin;
          r_addr    <= r_addr + 1'b1;
        end
      end else if (w_rd) begin
        r_latch <= 1'b0;
        if (cpuPortSel) begin
          cpuDout    <= statusIn;
          statusRead <= 1'b1;
        end else begin
          cpuDout <= r_readBuf;
          r_addr  <= r_addr + 1'b1;
        end
      end
      // Completed prefetch takes priority over a same-cycle CPU data write.
      if (r_state == ST_RD_CAP) r_readBuf <= vramOut;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pfCount <= '0;
      overflow  <= 1'b0;
    end else begin
      if (w_enq && w_full) overflow <= 1'b1;
      case ({w_push && (w_enqEntry.kind == OP_PREFETCH),
             w_pop && (w_head.kind == OP_PREFETCH)})
        2'b10:   r_pfCount <= r_pfCount + 1'b1;
        2'b01:   r_pfCount <= r_pfCount - 1'b1;
        default: r_pfCount <= r_pfCount;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      vramAddr   <= '0;
      vramWe     <= 1'b0;
      vramWrData <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          vramWe <= 1'b0;
          if (w_pop) begin
            vramAddr <= w_head.addr;
            if (w_head.kind == OP_WRITE) begin
              vramWe     <= 1'b1;
              vramWrData <= w_head.data;
              r_state    <= ST_WRITE;
            end else begin
              r_state <= ST_RD_ADDR;
            end
          end
        end
        ST_WRITE: begin
          vramWe  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_RD_ADDR: r_state <= ST_RD_CAP;
        ST_RD_CAP:  r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port with a VRAM model and a write scoreboard.
module tb_vdp_cpu_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpuWr, cpuRd, cpuPortSel;
  logic [7:0]  cpuDin, cpuDout, statusIn;
  logic        statusRead, vramGrant, vramWe;
  logic [13:0] vramAddr;
  logic [7:0]  vramWrData, vramOut;
  logic [4:0]  cramAddr;
  logic [5:0]  cramData;
  logic        cramWe;
  logic [3:0]  regAddr;
  logic [7:0]  regData;
  logic        regWe, fifoFull, overflow, prefetchBusy;

  typedef struct packed {
    logic [13:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        q[$];
  wr_t        mon_exp;
  int         total = 0;
  int         bad   = 0;
  logic [7:0] mem [0:16383];

  always #5 clk = ~clk;

  vdp_cpu_port #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cpuWr(cpuWr), .cpuRd(cpuRd),
    .cpuPortSel(cpuPortSel), .cpuDin(cpuDin), .cpuDout(cpuDout),
    .statusIn(statusIn), .statusRead(statusRead), .vramGrant(vramGrant),
    .vramAddr(vramAddr), .vramWe(vramWe), .vramWrData(vramWrData),
    .vramOut(vramOut), .cramAddr(cramAddr), .cramData(cramData),
    .cramWe(cramWe), .regAddr(regAddr), .regData(regData), .regWe(regWe),
    .fifoFull(fifoFull), .overflow(overflow), .prefetchBusy(prefetchBusy)
  );

  always @(posedge clk) begin
    if (vramWe) mem[vramAddr] <= vramWrData;
    vramOut <= mem[vramAddr];
  end

  // Every VRAM write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && vramWe) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL vram_unexpected: got 0x%0h@0x%0h expected no write", vramWrData, vramAddr);
      end
      if (q.size() != 0) begin
        mon_exp = q.pop_front();
        total++;
        assert ({vramAddr, vramWrData} === {mon_exp.a, mon_exp.d}) else begin
          bad++;
          $error("FAIL vram_write: got 0x%0h@0x%0h expected 0x%0h@0x%0h",
                 vramWrData, vramAddr, mon_exp.d, mon_exp.a);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic sel, input logic [7:0] d);
    @(posedge clk); #1;
    cpuWr = 1'b1; cpuPortSel = sel; cpuDin = d;
    @(posedge clk); #1;
    cpuWr = 1'b0;
  endtask

  task automatic cpu_rd(input logic sel);
    @(posedge clk); #1;
    cpuRd = 1'b1; cpuPortSel = sel;
    @(posedge clk); #1;
    cpuRd = 1'b0;
  endtask

  task automatic expect_wr(input logic [13:0] a, input logic [7:0] d);
    q.push_back('{a: a, d: d});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && (q.size() != 0 || prefetchBusy || vramWe); i++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_pending"}, 64'(q.size()), 64'd0);
    chk({tag, "_busy"}, 64'(prefetchBusy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpuWr = 1'b0; cpuRd = 1'b0; cpuPortSel = 1'b0; cpuDin = '0;
    statusIn = 8'h9C; vramGrant = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("reset_outs", {cpuDout, statusRead, vramAddr, vramWe, vramWrData, cramAddr,
        cramData, cramWe, regAddr, regData, regWe, fifoFull, overflow, prefetchBusy}, '0);
    rst = 1'b0;
    vramGrant = 1'b1;

    // Two VRAM writes, then confirm the address advanced to 2.
    cpu_wr(1'b1, 8'h00); cpu_wr(1'b1, 8'h40);
    chk("wr_setup_no_prefetch", 64'(prefetchBusy), 64'd0);
    expect_wr(14'h0000, 8'hAA); cpu_wr(1'b0, 8'hAA);
    expect_wr(14'h0001, 8'hBB); cpu_wr(1'b0, 8'hBB);
    drain("wr_pair");
    expect_wr(14'h0002, 8'h11); cpu_wr(1'b0, 8'h11);
    drain("wr_addr");

    // Register write: one-cycle pulse, nothing queued.
    cpu_wr(1'b1, 8'h26); cpu_wr(1'b1, 8'h81);
    chk("reg_pulse", {regWe, regAddr, regData}, {1'b1, 4'h1, 8'h26});
    chk("reg_no_fifo", {fifoFull, prefetchBusy}, 2'b00);
    @(posedge clk); #1;
    chk("reg_pulse_end", 64'(regWe), 64'd0);

    // CRAM writes use the low address bits and then advance.
    cpu_wr(1'b1, 8'h05); cpu_wr(1'b1, 8'hC0);
    cpu_wr(1'b0, 8'h3F);
    chk("cram_first", {cramWe, cramAddr, cramData}, {1'b1, 5'd5, 6'h3F});
    @(posedge clk); #1;
    chk("cram_pulse_end", 64'(cramWe), 64'd0);
    cpu_wr(1'b0, 8'h2A);
    chk("cram_second", {cramWe, cramAddr, cramData}, {1'b1, 5'd6, 6'h2A});

    // Fill the FIFO with the renderer holding VRAM; the fifth op is dropped.
    vramGrant = 1'b0;
    cpu_wr(1'b1, 8'h00); cpu_wr(1'b1, 8'h40);
    for (int i = 1; i <= 3; i++) begin
      expect_wr(14'(i - 1), 8'(i));
      cpu_wr(1'b0, 8'(i));
    end
    chk("fifo_not_full_3", 64'(fifoFull), 64'd0);
    expect_wr(14'h0003, 8'h04); cpu_wr(1'b0, 8'h04);
    chk("fifo_full_4", {fifoFull, overflow}, 2'b10);
    cpu_wr(1'b0, 8'h05);
    chk("fifo_overflow_5", {fifoFull, overflow}, 2'b11);
    vramGrant = 1'b1;
    drain("fifo_drain");
    expect_wr(14'h0005, 8'h66); cpu_wr(1'b0, 8'h66);
    drain("fifo_addr_after_drop");
    chk("overflow_sticky", 64'(overflow), 64'd1);

    // Prefetch across the 14-bit wrap.
    mem[14'h3FFF] = 8'h5A;
    mem[14'h0000] = 8'hC3;
    cpu_wr(1'b1, 8'hFF); cpu_wr(1'b1, 8'h3F);
    chk("pf_busy_set", 64'(prefetchBusy), 64'd1);
    drain("pf_first");
    cpu_rd(1'b0);
    chk("pf_read_3fff", 64'(cpuDout), 64'h5A);
    chk("pf_next_queued", 64'(prefetchBusy), 64'd1);
    drain("pf_second");
    cpu_rd(1'b0);
    chk("pf_read_0000", 64'(cpuDout), 64'hC3);
    drain("pf_third");

    // Status read clears a half-written address latch.
    cpu_wr(1'b1, 8'h12);
    cpu_rd(1'b1);
    chk("status_read", {statusRead, cpuDout}, {1'b1, 8'h9C});
    @(posedge clk); #1;
    chk("status_pulse_end", 64'(statusRead), 64'd0);
    cpu_wr(1'b1, 8'h34); cpu_wr(1'b1, 8'h40);
    expect_wr(14'h0034, 8'h77); cpu_wr(1'b0, 8'h77);
    drain("latch_cleared");

    // Asynchronous reset mid-stream flushes queued writes.
    vramGrant = 1'b0;
    cpu_wr(1'b0, 8'h88); cpu_wr(1'b0, 8'h99);
    #3 rst = 1'b1;
    #2;
    chk("reset_flush_outs", {cpuDout, statusRead, vramAddr, vramWe, vramWrData, cramAddr,
        cramData, cramWe, regAddr, regData, regWe, fifoFull, overflow, prefetchBusy}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    vramGrant = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("reset_flush_idle", {fifoFull, prefetchBusy, vramWe}, 3'b000);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
